gaussian_window_ctrl: RTL and testbench
=======================================

Name: gaussian_window_ctrl

Overview:
- Frame-level sequencer for gaussian_core.
- Accepts a raster pixel stream and holds 6 line buffers plus a 7x7 window register array.
- Drives the 392-bit window bus into gaussian_core and tracks the core's fixed latency.
- Returns filtered pixels through a credit-protected output FIFO with valid/ready, and signals end-of-frame.

Parameters:
- IMG_W, 64: pixels per line (>= 7).
- IMG_H, 64: lines per frame (>= 7).
- CORE_LAT, 1: gaussian_core cycles from window in to pixel out (>= 1).
- OFIFO_DEPTH, 4: output FIFO entries (>= CORE_LAT+1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle pulse; begins a frame when idle.
- s_valid  in  1  input pixel valid.
- s_ready  out  1  input pixel accepted when s_valid && s_ready.
- s_pixel  in  8  input pixel, raster order.
- core_pixels  out  392  7x7 window to gaussian_core.
- core_result  in  8  gaussian_core output pixel.
- m_valid  out  1  filtered pixel valid.
- m_ready  in  1  downstream accepts.
- m_pixel  out  8  filtered pixel.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  one-cycle pulse at frame completion.

Behaviour:
- Reset values (async, immediate): state=IDLE; all outputs 0 (s_ready, m_valid, m_pixel, busy, done, core_pixels); counters, window registers, FIFO pointers and in-flight shift register cleared. Line-buffer contents need not be cleared.
- States:
  - IDLE -> RUN on start.
  - RUN -> DRAIN when the IMG_W*IMG_H-th pixel is accepted.
  - DRAIN -> DONE when in-flight count == 0 and FIFO is empty.
  - DONE -> IDLE after one cycle; done=1 only in DONE.
  - start outside IDLE is ignored.
- Counters: x_cnt 0..IMG_W-1 and y_cnt 0..IMG_H-1, incremented per accepted pixel. x wraps to 0 and increments y.
- Window:
  - On accept, each window row shifts left by one column. Column 6 gets the new pixel (row 6) and line buffers 0..5 at x_cnt (rows 0..5).
  - Line buffers shift up one row at that column.
  - Element k = r*7+c (r=0 top/oldest line, c=0 leftmost/oldest) occupies core_pixels[391-8k -: 8], so k=0 is the MSBs.
- Issue:
  - A window is issued in the cycle after an accept whose (x_cnt, y_cnt) had x>=6 and y>=6.
  - The issue bit enters a CORE_LAT-deep valid shift register.
  - When it exits, core_result is written into the FIFO.
  - Outputs per frame: (IMG_W-6)*(IMG_H-6). Border positions produce no output.
  - Window columns spanning a line wrap are never issued, because the x>=6 rule excludes them.
- Credit rule: s_ready = (state==RUN) && (FIFO free entries > in-flight count). Overflow is therefore impossible regardless of m_ready.
- FIFO:
  - Standard circular buffer; m_valid = !empty; m_pixel = head entry.
  - Simultaneous push and pop on a full FIFO is legal; count is unchanged.
- core_pixels holds its value while no pixel is accepted.
- rst mid-frame aborts immediately to IDLE. FIFO contents and in-flight results are discarded; done is not pulsed.

Optional Feature:
- Macro: STALL_CNT_EN.
- Defined:
  - Adds output port stall_cycles [31:0].
  - Counts cycles in RUN with s_valid && !s_ready; saturates at 0xFFFFFFFF.
  - Cleared by rst and on the IDLE->RUN transition.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package gaussian_pkg:
  - WIN_DIM=7, PIX_W=8, WIN_BITS=392.
  - State enum {IDLE, RUN, DRAIN, DONE}.
  - Function win_idx(r,c)=r*7+c.
- One sub-module, gaussian_line_buffer: 6 rows x IMG_W x 8 bits, with column-indexed read and shift-up write on accept.
- FIFO and control logic stay inline.

Test Plan:
- Bench setup for all scenarios: IMG_W=8, IMG_H=8, CORE_LAT=1, and a stub core returning element k=24 (centre) after one clock.
- Ramp: pixel=y*8+x, s_valid constant, m_ready=1. Expect exactly 4 outputs 27,28,35,36 in order; done pulses once; busy low afterwards.
- Backpressure: same ramp with m_ready=0 for the whole frame.
  - s_ready drops once FIFO plus in-flight equals 4.
  - No output is lost or duplicated after m_ready=1 is restored.
  - Outputs remain 27,28,35,36.
- Bubbles: s_valid toggled pseudo-randomly with the ramp. Expect the same 4 values, and core_pixels unchanged in cycles with no accept.
- Reset mid-frame: assert rst after the 30th accepted pixel.
  - Outputs go to 0 immediately; no done pulse.
  - A new start with the ramp yields 27,28,35,36.
- Start while busy: pulse start during RUN and DRAIN. Expect no effect, and exactly one done pulse for the frame.
- STALL_CNT_EN: hold m_ready=0 until s_ready drops, then keep s_valid=1 for 10 more cycles. Expect stall_cycles == 10.

Source files
------------

// File: rtl/gaussian_pkg.sv
// Shared constants, FSM state type and window indexing helper for the
// gaussian window controller.
package gaussian_pkg;

  localparam int WIN_DIM  = 7;
  localparam int PIX_W    = 8;
  localparam int WIN_BITS = 392;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  function automatic int win_idx(input int r, input int c);
    return r * WIN_DIM + c;
  endfunction

endpackage

// File: rtl/gaussian_window_ctrl_if.sv
// Pixel stream, filtered output stream, core window bus and frame control.
// slave = controller side, master = environment side.
interface gaussian_window_ctrl_if;
  import gaussian_pkg::*;

  logic                start;
  logic                s_valid;
  logic                s_ready;
  logic [PIX_W-1:0]    s_pixel;
  logic [WIN_BITS-1:0] core_pixels;
  logic [PIX_W-1:0]    core_result;
  logic                m_valid;
  logic                m_ready;
  logic [PIX_W-1:0]    m_pixel;
  logic                busy;
  logic                done;

  modport master (
    output start, s_valid, s_pixel, core_result, m_ready,
    input  s_ready, core_pixels, m_valid, m_pixel, busy, done
  );

  modport slave (
    input  start, s_valid, s_pixel, core_result, m_ready,
    output s_ready, core_pixels, m_valid, m_pixel, busy, done
  );

endinterface

// File: rtl/gaussian_line_buffer.sv
// Six previous lines of pixels; one column is read and shifted up per accept.
// Row 0 holds the oldest line, row 5 the most recent complete line.
module gaussian_line_buffer
  import gaussian_pkg::*;
#(
  parameter int IMG_W = 64,
  localparam int XW = $clog2(IMG_W)
) (
  input  logic                             clk,
  input  logic                             wr_en,
  input  logic [XW-1:0]                    col,
  input  logic [PIX_W-1:0]                 pix_in,
  output logic [WIN_DIM-2:0][PIX_W-1:0]    col_data
);

  logic [PIX_W-1:0] mem [WIN_DIM-1][IMG_W];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int r = 0; r < WIN_DIM - 2; r++) mem[r][col] <= mem[r+1][col];
      mem[WIN_DIM-2][col] <= pix_in;
    end
  end

  for (genvar r = 0; r < WIN_DIM - 1; r++) begin : g_rd
    assign col_data[r] = mem[r][col];
  end

endmodule

// File: rtl/gaussian_window_ctrl.sv
// Frame sequencer feeding 7x7 windows to gaussian_core and buffering its results.
// Optional macro STALL_CNT_EN adds the stall_cycles input-stall counter port.
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | accepting frame pixels
//   DRAIN | last pixel taken, emptying core pipe and output FIFO
//   DONE  | one-cycle completion pulse
module gaussian_window_ctrl
  import gaussian_pkg::*;
#(
  parameter int IMG_W       = 64,
  parameter int IMG_H       = 64,
  parameter int CORE_LAT    = 1,
  parameter int OFIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  gaussian_window_ctrl_if.slave bus
`ifdef STALL_CNT_EN
  ,
  output logic [31:0]           stall_cycles
`endif
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam int PW = $clog2(OFIFO_DEPTH);
  localparam int CW = $clog2(OFIFO_DEPTH + 1);
  localparam int IW = $clog2(CORE_LAT + 2);

  state_t                               state;
  logic                                 busy_q, done_q;
  logic [XW-1:0]                        x_cnt;
  logic [YW-1:0]                        y_cnt;
  logic [WIN_DIM-1:0][WIN_DIM-1:0][PIX_W-1:0] win;
  logic [WIN_DIM-2:0][PIX_W-1:0]        lb_col;
  logic                                 issue_q;
  logic [CORE_LAT-1:0]                  lat_sr;
  logic [IW-1:0]                        inflight;
  logic [PIX_W-1:0]                     fifo_mem [OFIFO_DEPTH];
  logic [PW-1:0]                        wr_ptr, rd_ptr;
  logic [CW-1:0]                        fifo_cnt;
  logic                                 s_ready_i, accept, last_pix, push, pop;

  always_comb begin
    inflight = IW'(issue_q);
    for (int i = 0; i < CORE_LAT; i++) inflight = inflight + IW'(lat_sr[i]);
  end

  // Every accepted pixel may become a result, so reserve a FIFO slot for each in flight.
  assign s_ready_i = (state == RUN) &&
                     ((OFIFO_DEPTH - int'(fifo_cnt)) > int'(inflight));
  assign accept    = bus.s_valid && s_ready_i;
  assign last_pix  = accept && (x_cnt == XW'(IMG_W - 1)) && (y_cnt == YW'(IMG_H - 1));
  assign push      = lat_sr[CORE_LAT-1];
  assign pop       = (fifo_cnt != '0) && bus.m_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          state  <= RUN;
          busy_q <= 1'b1;
        end
        RUN: if (last_pix) state <= DRAIN;
        DRAIN: if (inflight == '0 && fifo_cnt == '0) begin
          state  <= DONE;
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (state == IDLE && bus.start) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (accept) begin
      if (x_cnt == XW'(IMG_W - 1)) begin
        x_cnt <= '0;
        y_cnt <= (y_cnt == YW'(IMG_H - 1)) ? '0 : y_cnt + 1'b1;
      end else begin
        x_cnt <= x_cnt + 1'b1;
      end
    end
  end

  gaussian_line_buffer #(.IMG_W(IMG_W)) u_line_buf (
    .clk      (clk),
    .wr_en    (accept),
    .col      (x_cnt),
    .pix_in   (bus.s_pixel),
    .col_data (lb_col)
  );

  // Only positions with six columns and six lines of history form a full window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win     <= '0;
      issue_q <= 1'b0;
      lat_sr  <= '0;
    end else begin
      issue_q <= accept && (x_cnt >= XW'(WIN_DIM - 1)) && (y_cnt >= YW'(WIN_DIM - 1));
      lat_sr  <= (lat_sr << 1) | CORE_LAT'(issue_q);
      if (accept) begin
        for (int r = 0; r < WIN_DIM; r++)
          for (int c = 0; c < WIN_DIM - 1; c++) win[r][c] <= win[r][c+1];
        for (int r = 0; r < WIN_DIM - 1; r++) win[r][WIN_DIM-1] <= lb_col[r];
        win[WIN_DIM-1][WIN_DIM-1] <= bus.s_pixel;
      end
    end
  end

  for (genvar r = 0; r < WIN_DIM; r++) begin : g_win_r
    for (genvar c = 0; c < WIN_DIM; c++) begin : g_win_c
      assign bus.core_pixels[WIN_BITS - 1 - PIX_W * win_idx(r, c) -: PIX_W] = win[r][c];
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bus.core_result;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(OFIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PW'(OFIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

`ifdef STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (state == IDLE && bus.start) begin
      stall_cycles <= '0;
    end else if (state == RUN && bus.s_valid && !s_ready_i && stall_cycles != '1) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

  assign bus.s_ready = s_ready_i;
  assign bus.m_valid = (fifo_cnt != '0);
  assign bus.m_pixel = (fifo_cnt != '0) ? fifo_mem[rd_ptr] : '0;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_gaussian_window_ctrl.sv
// Directed bench for gaussian_window_ctrl on an 8x8 frame with a one-cycle
// centre-tap core stub; expected outputs for the ramp are 27, 28, 35, 36.
module tb_gaussian_window_ctrl;
  import gaussian_pkg::*;

  localparam int NPIX = 64;
  localparam int CTR  = WIN_BITS - 1 - PIX_W * 24;
  localparam logic [7:0] EXP_VALS [4] = '{8'd27, 8'd28, 8'd35, 8'd36};

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  gaussian_window_ctrl_if bus ();

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int hold_bad = 0;
  logic [7:0] outq [$];

`ifdef STALL_CNT_EN
  logic [31:0] stall_a, stall_b;
  gaussian_window_ctrl_if bus2 ();

  gaussian_window_ctrl #(.IMG_W(8), .IMG_H(8), .CORE_LAT(1), .OFIFO_DEPTH(2)) u_dut2 (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus2),
    .stall_cycles (stall_b)
  );

  always @(posedge clk) bus2.core_result <= bus2.core_pixels[CTR -: PIX_W];
`endif

  gaussian_window_ctrl #(.IMG_W(8), .IMG_H(8), .CORE_LAT(1), .OFIFO_DEPTH(4)) u_dut (
    .clk          (clk),
    .rst          (rst),
`ifdef STALL_CNT_EN
    .stall_cycles (stall_a),
`endif
    .bus          (bus)
  );

  always @(posedge clk) bus.core_result <= bus.core_pixels[CTR -: PIX_W];

  always @(negedge clk) begin
    if (bus.m_valid && bus.m_ready) outq.push_back(bus.m_pixel);
    if (bus.done) done_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic start_frame();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic send_pixels(input bit bubbles, input int npix, input int start_at);
    int p = 0;
    int guard = 0;
    bit acc;
    logic [WIN_BITS-1:0] cp_prev;
    while (p < npix && guard < 2000) begin
      bus.s_valid = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.s_pixel = 8'(p);
      bus.start   = (p == start_at);
      acc     = bus.s_valid && bus.s_ready;
      cp_prev = bus.core_pixels;
      @(posedge clk); #1;
      if (acc) p++;
      else if (bus.core_pixels !== cp_prev) hold_bad++;
      guard++;
    end
    bus.s_valid = 1'b0;
    bus.start   = 1'b0;
    check("pixels_accepted", 64'(p), 64'(npix));
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (bus.busy && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, 64'(n < 300), 64'd1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input string tag, input int qb, input int db);
    check({tag, "_count"}, 64'(outq.size() - qb), 64'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("%s_out%0d", tag, i),
            (qb + i < outq.size()) ? 64'(outq[qb + i]) : 64'hx, 64'(EXP_VALS[i]));
    check({tag, "_done_pulses"}, 64'(done_cnt - db), 64'd1);
    check({tag, "_busy_after"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int qb, db;
    bus.start   = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_pixel = '0;
    bus.m_ready = 1'b1;
`ifdef STALL_CNT_EN
    bus2.start   = 1'b0;
    bus2.s_valid = 1'b0;
    bus2.s_pixel = '0;
    bus2.m_ready = 1'b1;
`endif
    rst = 1'b1;
    #12;
    check("rst_s_ready", 64'(bus.s_ready), 64'd0);
    check("rst_m_valid", 64'(bus.m_valid), 64'd0);
    check("rst_m_pixel", 64'(bus.m_pixel), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_core_zero", 64'(bus.core_pixels === '0), 64'd1);
    #5 rst = 1'b0;
    @(posedge clk); #1;

    // Ramp, full throughput
    qb = outq.size(); db = done_cnt;
    start_frame();
    check("ramp_busy_run", 64'(bus.busy), 64'd1);
    check("ramp_s_ready_run", 64'(bus.s_ready), 64'd1);
    send_pixels(1'b0, NPIX, -1);
    wait_idle("ramp_finish");
    check_frame("ramp", qb, db);

    // Backpressure for the whole frame
    bus.m_ready = 1'b0;
    qb = outq.size(); db = done_cnt;
    start_frame();
    send_pixels(1'b0, NPIX, -1);
    repeat (5) @(posedge clk);
    #1;
    check("bp_s_ready_low", 64'(bus.s_ready), 64'd0);
    check("bp_busy_held", 64'(bus.busy), 64'd1);
    check("bp_m_valid", 64'(bus.m_valid), 64'd1);
    check("bp_head", 64'(bus.m_pixel), 64'd27);
    check("bp_no_done", 64'(done_cnt - db), 64'd0);
    bus.m_ready = 1'b1;
    wait_idle("bp_finish");
    check_frame("bp", qb, db);

    // Random input bubbles
    qb = outq.size(); db = done_cnt; hold_bad = 0;
    start_frame();
    send_pixels(1'b1, NPIX, -1);
    wait_idle("bub_finish");
    check_frame("bub", qb, db);
    check("bub_core_hold", 64'(hold_bad), 64'd0);

    // Reset after the 30th accepted pixel
    db = done_cnt;
    start_frame();
    send_pixels(1'b0, 30, -1);
    check("pre_rst_core_loaded", 64'(bus.core_pixels !== '0), 64'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 64'(bus.busy), 64'd0);
    check("mid_rst_s_ready", 64'(bus.s_ready), 64'd0);
    check("mid_rst_m_valid", 64'(bus.m_valid), 64'd0);
    check("mid_rst_core_zero", 64'(bus.core_pixels === '0), 64'd1);
    #3 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("mid_rst_no_done", 64'(done_cnt - db), 64'd0);
    qb = outq.size(); db = done_cnt;
    start_frame();
    send_pixels(1'b0, NPIX, -1);
    wait_idle("after_rst_finish");
    check_frame("after_rst", qb, db);

    // Start pulses during RUN and DRAIN are ignored
    qb = outq.size(); db = done_cnt;
    start_frame();
    send_pixels(1'b0, NPIX, 20);
    check("drain_busy", 64'(bus.busy), 64'd1);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_idle("busy_start_finish");
    repeat (10) @(posedge clk);
    #1;
    check_frame("busy_start", qb, db);

`ifdef STALL_CNT_EN
    check("stall_none_main", 64'(stall_a), 64'd0);
    begin
      int p2 = 0;
      int stalls = 0;
      int n2 = 0;
      bus2.m_ready = 1'b0;
      bus2.start = 1'b1;
      @(posedge clk); #1;
      bus2.start = 1'b0;
      while (stalls < 10 && n2 < 500) begin
        bus2.s_valid = 1'b1;
        bus2.s_pixel = 8'(p2);
        if (bus2.s_ready) p2++;
        else stalls++;
        @(posedge clk); #1;
        n2++;
      end
      bus2.s_valid = 1'b0;
      check("stall_reached", 64'(stalls), 64'd10);
    end
    repeat (3) @(posedge clk);
    #1;
    check("stall_cycles", 64'(stall_b), 64'd10);
    rst = 1'b1;
    #1;
    check("stall_rst_clear", 64'(stall_b), 64'd0);
    #3 rst = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
